alu_seq_core: RTL and testbench
===============================

// Module: alu_seq_core
// PURPOSE
//  Parametrised, clocked successor to the combinational ALU: W-bit datapath with a persistent CARRY flag for
//  multi-word ADD/SUB chains and multi-cycle iterative shift-by-N (and optional multiply) behind a valid/ready handshake.
//  Sits between register-file read and write-back; the control unit issues one op when IN_READY and writes OUT back on OUT_VALID.
// PARAMETERS
//  W     8            datapath width (>=4)
//  IMMW  5            immediate width; must be >= SHW
//  SHW   $clog2(W)    shift-amount width (localparam, derived)
// PORTS
//  CLK        in   1     clock, rising edge
//  RESET_N    in   1     asynchronous reset, active low
//  IN_VALID   in   1     op request
//  IN_READY   out  1     core idle; request accepted on edge where IN_VALID&IN_READY
//  OP         in   4     opcode (op_e)
//  T          in   1     toggle/modifier bit
//  INPUTA     in   W     operand A (rs)
//  INPUTB     in   W     operand B (r0/accumulator)
//  IMM        in   IMMW  immediate / shift amount
//  OUT        out  W     result, registered, held until next result
//  HI         out  W     multiply high half; constant 0 without ALU_SEQ_MUL_EN
//  OUT_VALID  out  1     one-cycle pulse: OUT/HI/ZERO/CARRY updated
//  ZERO       out  1     registered (OUT==0); HI excluded
//  CARRY      out  1     persistent carry/borrow flag
//  ERR        out  1     one-cycle pulse with OUT_VALID for illegal opcode
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-low. Reset: state IDLE, OUT/HI/ZERO/CARRY/OUT_VALID/ERR=0, IN_READY=1.
//  FSM: IDLE -> BUSY on accepted SHL/SHR with IMM[SHW-1:0]!=0, or MUL; BUSY -> IDLE when count reaches 0. IN_READY = (state==IDLE).
//  Single-cycle ops: accepted on edge E0, results + OUT_VALID visible after E0; back-to-back accepts allowed every cycle.
//  Iterative ops: E0 loads work reg and count k; edges E1..Ek each do one step; result + OUT_VALID visible after Ek.
//  IN_VALID while BUSY: ignored, no side effects. No output backpressure; OUT_VALID never stalls.
//  ADD  {c,OUT}=A+B+(T?CARRY:0); CARRY<=c.      SUB  OUT=A-B-(T?CARRY:0); CARRY<=borrow (1 if A < B+bin).
//  XOR/AND/OR  bitwise; CARRY unchanged.        ACC  OUT=zero-extended IMM; CARRY unchanged.
//  SHL  k=IMM[SHW-1:0] cycles, zero fill; CARRY<=last bit shifted out.
//  SHR  as SHL; T=0 logical (zero fill), T=1 arithmetic (sign fill).
//  k==0: single-cycle pass-through, OUT=A, CARRY unchanged.
//  EQ   OUT=(A==B)^T (T=1 -> not-equal), zero-extended.   LT  OUT=(A<B), T=0 unsigned, T=1 signed; CARRY unchanged for both.
//  Illegal opcode: single-cycle, OUT=0, ZERO=1, CARRY/HI unchanged, ERR pulses.
//  Reset mid-BUSY: op abandoned, no OUT_VALID, all outputs to reset values.
//  HI only written by MUL; all other ops leave HI unchanged.
// CONFIGURATION
//  Macro ALU_SEQ_MUL_EN defined: MUL = unsigned A*B via shift-add, k=W BUSY cycles; {HI,OUT}=product, CARRY<=(HI!=0).
//  Macro absent: MUL decodes as illegal (ERR pulse, OUT=0); HI tied 0, no multiplier logic.
// STRUCTURE
//  alu_seq_pkg: op_e enum (ADD=0 SUB=1 XOR=2 AND=3 OR=4 SHL=5 SHR=6 EQ=7 LT=8 ACC=9 MUL=10; 11-15 illegal), state_e {IDLE,BUSY}.
//  Sub-module alu_seq_iter: owns work regs, step counter and the shift/shift-add step; top owns decode, single-cycle ops, flags, handshake.
// TESTING
//  1 Assert RESET_N=0 mid-sim -> OUT=0, ZERO=0, CARRY=0, OUT_VALID=0, ERR=0, IN_READY=1 immediately (async).
//  2 ADD A=8'hF0 B=8'h20 T=0 -> OUT=8'h10, CARRY=1; then ADD A=0 B=0 T=1 -> OUT=8'h01, CARRY=0, ZERO=0.
//  3 SHL A=8'h81 IMM=3 -> IN_READY low 3 cycles, OUT=8'h08, CARRY=0; SHR T=1 A=8'h80 IMM=2 -> OUT=8'hE0, CARRY=0.
//  4 IN_VALID held high with new op during BUSY -> ignored; next op accepted on first edge IN_READY=1, one OUT_VALID each.
//  5 RESET_N pulsed during SHL k=5 -> no OUT_VALID, OUT=0; subsequent XOR 8'h0F^8'h0F -> OUT=0, ZERO=1.
//  6 MUL 8'hFF*8'hFF: macro on -> after 8 BUSY cycles HI=8'hFE, OUT=8'h01, CARRY=1; macro off -> ERR pulse, OUT=0, ZERO=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and iterative-unit modes.
// The multiply opcode is only legal when the build defines ALU_SEQ_MUL_EN.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_XOR = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_EQ  = 4'd7,
        OP_LT  = 4'd8,
        OP_ACC = 4'd9,
        OP_MUL = 4'd10
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_MUL = 2'd2
    } iter_mode_e;

endpackage

// File: rtl/alu_seq_iter.sv
// Multi-cycle engine: one shift (or shift-add multiply step, with ALU_SEQ_MUL_EN) per clock.
// Exposes the next-step values so the owner can capture the final result on the last step's edge.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  iter_mode_e    i_mode,
    input  logic          i_arith,
    input  logic [CW-1:0] i_count,
    input  logic [W-1:0]  i_a,
`ifdef ALU_SEQ_MUL_EN
    input  logic [W-1:0]  i_b,
    output logic [W-1:0]  o_hi_next,
    output logic          o_mul,
`endif
    output logic          o_last,
    output logic [W-1:0]  o_lo_next,
    output logic          o_carry_next
);

    iter_mode_e    r_mode;
    logic          r_arith;
    logic [CW-1:0] r_count;
    logic [W-1:0]  r_lo;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]  r_hi;
    logic [W-1:0]  r_mcand;
    logic [W:0]    w_sum;

    // Partial product: add the multiplicand when the current multiplier LSB is set.
    assign w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
    assign o_hi_next = w_sum[W:1];
    assign o_mul     = (r_mode == IT_MUL);
`endif

    assign o_last = (r_count == CW'(1));

    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        o_lo_next    = r_lo;
        o_carry_next = 1'b0;
        case (r_mode)
            IT_SHL: begin
                o_lo_next    = {r_lo[W-2:0], 1'b0};
                o_carry_next = r_lo[W-1];
            end
            IT_SHR: begin
                o_lo_next    = {r_arith & r_lo[W-1], r_lo[W-1:1]};
                o_carry_next = r_lo[0];
            end
`ifdef ALU_SEQ_MUL_EN
            IT_MUL: begin
                o_lo_next    = {w_sum[0], r_lo[W-1:1]};
                o_carry_next = |w_sum[W:1];
            end
`endif
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode  <= IT_SHL;
            r_arith <= 1'b0;
            r_count <= '0;
            r_lo    <= '0;
`ifdef ALU_SEQ_MUL_EN
            r_hi    <= '0;
            r_mcand <= '0;
`endif
        end else if (i_start) begin
            r_mode  <= i_mode;
            r_arith <= i_arith;
            r_count <= i_count;
`ifdef ALU_SEQ_MUL_EN
            r_hi    <= '0;
            r_mcand <= i_a;
            r_lo    <= (i_mode == IT_MUL) ? i_b : i_a;
`else
            r_lo    <= i_a;
`endif
        end else if (r_count != '0) begin
            r_count <= r_count - CW'(1);
            r_lo    <= o_lo_next;
`ifdef ALU_SEQ_MUL_EN
            r_hi    <= o_hi_next;
`endif
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Clocked ALU with persistent carry, iterative shifts and a valid/ready issue handshake.
// Define ALU_SEQ_MUL_EN to enable the W-cycle shift-add multiply and the HI result half.
module alu_seq_core #(
    parameter int W    = 8,
    parameter int IMMW = 5
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [3:0]      OP,
    input  logic            T,
    input  logic [W-1:0]    INPUTA,
    input  logic [W-1:0]    INPUTB,
    input  logic [IMMW-1:0] IMM,
    output logic [W-1:0]    OUT,
    output logic [W-1:0]    HI,
    output logic            OUT_VALID,
    output logic            ZERO,
    output logic            CARRY,
    output logic            ERR
);

    import alu_seq_pkg::*;

    localparam int SHW = $clog2(W);
    localparam int CW  = SHW + 1;

    state_e        r_state;
    logic [W-1:0]  r_out;
    logic          r_zero;
    logic          r_carry;
    logic          r_out_valid;
    logic          r_err;

    op_e           w_op;
    logic          w_accept;
    logic [SHW-1:0] w_k;
    logic          w_cin;
    logic [W:0]    w_add;
    logic [W:0]    w_sub;
    logic          w_start;
    iter_mode_e    w_mode;
    logic [CW-1:0] w_cnt;
    logic [W-1:0]  w_res;
    logic          w_res_carry;
    logic          w_err;
    logic          w_it_last;
    logic [W-1:0]  w_it_lo;
    logic          w_it_carry;

    assign w_op     = op_e'(OP);
    assign w_accept = IN_VALID && (r_state == ST_IDLE);
    assign w_k      = IMM[SHW-1:0];
    assign w_cin    = T & r_carry;
    assign w_add    = {1'b0, INPUTA} + {1'b0, INPUTB} + {{W{1'b0}}, w_cin};
    // Borrow falls out as the extra MSB of the widened difference.
    assign w_sub    = {1'b0, INPUTA} - {1'b0, INPUTB} - {{W{1'b0}}, w_cin};

    always_comb begin
        w_start     = 1'b0;
        w_mode      = IT_SHL;
        w_cnt       = '0;
        w_res       = INPUTA;
        w_res_carry = r_carry;
        w_err       = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res       = w_add[W-1:0];
                w_res_carry = w_add[W];
            end
            OP_SUB: begin
                w_res       = w_sub[W-1:0];
                w_res_carry = w_sub[W];
            end
            OP_XOR: w_res = INPUTA ^ INPUTB;
            OP_AND: w_res = INPUTA & INPUTB;
            OP_OR:  w_res = INPUTA | INPUTB;
            OP_SHL, OP_SHR: begin
                // A zero shift amount completes immediately as a pass-through of A.
                if (w_k != '0) begin
                    w_start = 1'b1;
                    w_mode  = (w_op == OP_SHL) ? IT_SHL : IT_SHR;
                    w_cnt   = CW'(w_k);
                end
            end
            OP_EQ:  w_res = {{(W-1){1'b0}}, (INPUTA == INPUTB) ^ T};
            OP_LT:  w_res = {{(W-1){1'b0}}, T ? ($signed(INPUTA) < $signed(INPUTB)) : (INPUTA < INPUTB)};
            OP_ACC: w_res = W'(IMM);
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
                w_start = 1'b1;
                w_mode  = IT_MUL;
                w_cnt   = CW'(W);
            end
`endif
            default: begin
                w_res = '0;
                w_err = 1'b1;
            end
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0] r_hi;
    logic [W-1:0] w_it_hi;
    logic         w_it_mul;
`endif

    alu_seq_iter #(
        .W  (W),
        .CW (CW)
    ) u_iter (
        .i_clk        (CLK),
        .i_rst_n      (RESET_N),
        .i_start      (w_accept & w_start),
        .i_mode       (w_mode),
        .i_arith      (T),
        .i_count      (w_cnt),
        .i_a          (INPUTA),
`ifdef ALU_SEQ_MUL_EN
        .i_b          (INPUTB),
        .o_hi_next    (w_it_hi),
        .o_mul        (w_it_mul),
`endif
        .o_last       (w_it_last),
        .o_lo_next    (w_it_lo),
        .o_carry_next (w_it_carry)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_out       <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            if (r_state == ST_BUSY) begin
                if (w_it_last) begin
                    r_state     <= ST_IDLE;
                    r_out       <= w_it_lo;
                    r_zero      <= (w_it_lo == '0);
                    r_carry     <= w_it_carry;
                    r_out_valid <= 1'b1;
                end
            end else if (w_accept) begin
                if (w_start) begin
                    r_state <= ST_BUSY;
                end else begin
                    r_out       <= w_res;
                    r_zero      <= (w_res == '0);
                    r_carry     <= w_res_carry;
                    r_err       <= w_err;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_SEQ_MUL_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hi <= '0;
        end else if (r_state == ST_BUSY && w_it_last && w_it_mul) begin
            r_hi <= w_it_hi;
        end
    end
    assign HI = r_hi;
`else
    assign HI = '0;
`endif

    assign IN_READY  = (r_state == ST_IDLE);
    assign OUT       = r_out;
    assign ZERO      = r_zero;
    assign CARRY     = r_carry;
    assign OUT_VALID = r_out_valid;
    assign ERR       = r_err;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed self-checking bench for alu_seq_core (W=8, IMMW=5); MUL checks follow ALU_SEQ_MUL_EN.
module tb_alu_seq_core;

    import alu_seq_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b1;
    logic       IN_VALID = 1'b0;
    logic       IN_READY;
    logic [3:0] OP = 4'd0;
    logic       T = 1'b0;
    logic [7:0] INPUTA = 8'h00;
    logic [7:0] INPUTB = 8'h00;
    logic [4:0] IMM = 5'd0;
    logic [7:0] OUT;
    logic [7:0] HI;
    logic       OUT_VALID;
    logic       ZERO;
    logic       CARRY;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu_seq_core #(.W(8), .IMMW(5)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .T         (T),
        .INPUTA    (INPUTA),
        .INPUTB    (INPUTB),
        .IMM       (IMM),
        .OUT       (OUT),
        .HI        (HI),
        .OUT_VALID (OUT_VALID),
        .ZERO      (ZERO),
        .CARRY     (CARRY),
        .ERR       (ERR)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op, then wait (bounded) for its OUT_VALID; lat = edges after accept, -1 on timeout.
    task automatic run_op(input logic [3:0] op, input logic t, input logic [7:0] a,
                          input logic [7:0] b, input logic [4:0] imm,
                          output int lat, output int rdy_low);
        @(negedge CLK);
        OP = op; T = t; INPUTA = a; INPUTB = b; IMM = imm; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        lat = 0;
        rdy_low = 0;
        while (!OUT_VALID && lat < 40) begin
            if (!IN_READY) rdy_low++;
            @(posedge CLK); #1;
            lat++;
        end
        if (!OUT_VALID) lat = -1;
    endtask

    task automatic check_res(input string tag, input logic [3:0] op, input logic t,
                             input logic [7:0] a, input logic [7:0] b, input logic [4:0] imm,
                             input logic [7:0] exp_out, input logic exp_c, input logic exp_z,
                             input int exp_lat);
        int lat;
        int rdy_low;
        run_op(op, t, a, b, imm, lat, rdy_low);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_out"}, {24'd0, OUT}, {24'd0, exp_out});
        check({tag, "_carry"}, {31'd0, CARRY}, {31'd0, exp_c});
        check({tag, "_zero"}, {31'd0, ZERO}, {31'd0, exp_z});
        check({tag, "_rdylow"}, rdy_low, exp_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int lat;
        int rdy_low;

        // Power-on reset
        #2 RESET_N = 1'b0;
        #1;
        check("rst_out", {24'd0, OUT}, 32'h0);
        check("rst_ready", {31'd0, IN_READY}, 32'h1);
        check("rst_valid", {31'd0, OUT_VALID}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Arithmetic with carry chain
        check_res("add1",  OP_ADD, 1'b0, 8'hF0, 8'h20, 5'd0, 8'h10, 1'b1, 1'b0, 0);
        check_res("add2",  OP_ADD, 1'b1, 8'h00, 8'h00, 5'd0, 8'h01, 1'b0, 1'b0, 0);
        check_res("sub1",  OP_SUB, 1'b0, 8'h05, 8'h07, 5'd0, 8'hFE, 1'b1, 1'b0, 0);
        check_res("sub2",  OP_SUB, 1'b1, 8'h10, 8'h05, 5'd0, 8'h0A, 1'b0, 1'b0, 0);
        check_res("add3",  OP_ADD, 1'b0, 8'hFF, 8'h01, 5'd0, 8'h00, 1'b1, 1'b1, 0);

        // Logic / compare / immediate leave CARRY alone
        check_res("xor",   OP_XOR, 1'b0, 8'hA5, 8'hFF, 5'd0, 8'h5A, 1'b1, 1'b0, 0);
        check_res("and",   OP_AND, 1'b0, 8'hF0, 8'h3C, 5'd0, 8'h30, 1'b1, 1'b0, 0);
        check_res("or",    OP_OR,  1'b0, 8'h0F, 8'h30, 5'd0, 8'h3F, 1'b1, 1'b0, 0);
        check_res("ne",    OP_EQ,  1'b1, 8'h33, 8'h33, 5'd0, 8'h00, 1'b1, 1'b1, 0);
        check_res("eq",    OP_EQ,  1'b0, 8'h33, 8'h33, 5'd0, 8'h01, 1'b1, 1'b0, 0);
        check_res("lts",   OP_LT,  1'b1, 8'h80, 8'h01, 5'd0, 8'h01, 1'b1, 1'b0, 0);
        check_res("ltu",   OP_LT,  1'b0, 8'h80, 8'h01, 5'd0, 8'h00, 1'b1, 1'b1, 0);
        check_res("acc",   OP_ACC, 1'b0, 8'h00, 8'h00, 5'h1F, 8'h1F, 1'b1, 1'b0, 0);
        check_res("shl0",  OP_SHL, 1'b0, 8'h5C, 8'h00, 5'd8, 8'h5C, 1'b1, 1'b0, 0);

        // Illegal opcode
        run_op(4'hF, 1'b0, 8'h12, 8'h34, 5'd0, lat, rdy_low);
        check("ill_err", {31'd0, ERR}, 32'h1);
        check("ill_out", {24'd0, OUT}, 32'h0);
        check("ill_zero", {31'd0, ZERO}, 32'h1);
        check("ill_carry", {31'd0, CARRY}, 32'h1);
        @(posedge CLK); #1;
        check("ill_err_pulse", {31'd0, ERR}, 32'h0);

        // Iterative shifts
        check_res("shl3",  OP_SHL, 1'b0, 8'h81, 8'h00, 5'd3, 8'h08, 1'b0, 1'b0, 3);
        check_res("sra2",  OP_SHR, 1'b1, 8'h80, 8'h00, 5'd2, 8'hE0, 1'b0, 1'b0, 2);
        check_res("srl1",  OP_SHR, 1'b0, 8'h81, 8'h00, 5'd1, 8'h40, 1'b1, 1'b0, 1);

        // Asynchronous reset mid-simulation, away from any clock edge
        @(negedge CLK); #2;
        RESET_N = 1'b0;
        #1;
        check("arst_out", {24'd0, OUT}, 32'h0);
        check("arst_zero", {31'd0, ZERO}, 32'h0);
        check("arst_carry", {31'd0, CARRY}, 32'h0);
        check("arst_valid", {31'd0, OUT_VALID}, 32'h0);
        check("arst_err", {31'd0, ERR}, 32'h0);
        check("arst_ready", {31'd0, IN_READY}, 32'h1);
        @(negedge CLK);
        RESET_N = 1'b1;

        // IN_VALID held through BUSY with a different op waiting
        @(negedge CLK);
        OP = OP_SHL; T = 1'b0; INPUTA = 8'h01; INPUTB = 8'h00; IMM = 5'd2; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        OP = OP_XOR; INPUTA = 8'hAA; INPUTB = 8'h55;
        pulses = 0;
        @(posedge CLK); #1;
        check("hold_e1_valid", {31'd0, OUT_VALID}, 32'h0);
        check("hold_e1_ready", {31'd0, IN_READY}, 32'h0);
        @(posedge CLK); #1;
        if (OUT_VALID) pulses++;
        check("hold_e2_out", {24'd0, OUT}, 32'h04);
        check("hold_e2_ready", {31'd0, IN_READY}, 32'h1);
        @(posedge CLK); #1;
        if (OUT_VALID) pulses++;
        IN_VALID = 1'b0;
        check("hold_e3_out", {24'd0, OUT}, 32'hFF);
        repeat (3) begin
            @(posedge CLK); #1;
            if (OUT_VALID) pulses++;
        end
        check("hold_pulses", pulses, 2);

        // Reset abandons an in-flight shift
        @(negedge CLK);
        OP = OP_SHL; T = 1'b0; INPUTA = 8'hFF; IMM = 5'd5; IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (2) @(posedge CLK);
        #3 RESET_N = 1'b0;
        #1;
        check("abort_out", {24'd0, OUT}, 32'h0);
        check("abort_ready", {31'd0, IN_READY}, 32'h1);
        @(negedge CLK);
        RESET_N = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (OUT_VALID) pulses++;
        end
        check("abort_pulses", pulses, 0);
        check_res("xor0",  OP_XOR, 1'b0, 8'h0F, 8'h0F, 5'd0, 8'h00, 1'b0, 1'b1, 0);

        // Multiply
`ifdef ALU_SEQ_MUL_EN
        check_res("mul",   OP_MUL, 1'b0, 8'hFF, 8'hFF, 5'd0, 8'h01, 1'b1, 1'b0, 8);
        check("mul_hi", {24'd0, HI}, 32'hFE);
        check_res("add_hi", OP_ADD, 1'b0, 8'h01, 8'h01, 5'd0, 8'h02, 1'b0, 1'b0, 0);
        check("hi_kept", {24'd0, HI}, 32'hFE);
`else
        run_op(OP_MUL, 1'b0, 8'hFF, 8'hFF, 5'd0, lat, rdy_low);
        check("mul_lat", lat, 0);
        check("mul_err", {31'd0, ERR}, 32'h1);
        check("mul_out", {24'd0, OUT}, 32'h0);
        check("mul_zero", {31'd0, ZERO}, 32'h1);
        check("mul_hi", {24'd0, HI}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
